// File: rtl/fp_wrb_arbiter_if.sv
// Write-back bus between the four FP producers, the arbiter and the two
// regfile write ports. The master side is the producers/regfile side, the
// slave side is the arbiter itself.
interface fp_wrb_arbiter_if #(
   parameter int REG_SIZE_WIDTH = 6,
   parameter int DATA_WIDTH     = 64
);
   logic                      flush_i;

   logic                      falu1_wrb_valid_i;
   logic                      falu1_wrb_ready_o;
   logic [REG_SIZE_WIDTH-1:0] falu1_wrb_address_i;
   logic [DATA_WIDTH-1:0]     falu1_wrb_data_i;

   logic                      falu2_wrb_valid_i;
   logic                      falu2_wrb_ready_o;
   logic [REG_SIZE_WIDTH-1:0] falu2_wrb_address_i;
   logic [DATA_WIDTH-1:0]     falu2_wrb_data_i;

   logic                      lsu_wrb_valid_i;
   logic                      lsu_wrb_ready_o;
   logic [REG_SIZE_WIDTH-1:0] lsu_wrb_address_i;
   logic [DATA_WIDTH-1:0]     lsu_wrb_data_i;

   logic                      fdivsqrt_wrb_valid_i;
   logic                      fdivsqrt_wrb_ready_o;
   logic [REG_SIZE_WIDTH-1:0] fdivsqrt_wrb_address_i;
   logic [DATA_WIDTH-1:0]     fdivsqrt_wrb_data_i;

   logic                      wr_first_valid_o;
   logic [REG_SIZE_WIDTH-1:0] wr_first_address_o;
   logic [DATA_WIDTH-1:0]     wr_first_data_o;
   logic                      wr_second_valid_o;
   logic [REG_SIZE_WIDTH-1:0] wr_second_address_o;
   logic [DATA_WIDTH-1:0]     wr_second_data_o;
   logic [3:0]                wrb_done_o;

   modport master (
      output flush_i,
      output falu1_wrb_valid_i, falu1_wrb_address_i, falu1_wrb_data_i,
      output falu2_wrb_valid_i, falu2_wrb_address_i, falu2_wrb_data_i,
      output lsu_wrb_valid_i, lsu_wrb_address_i, lsu_wrb_data_i,
      output fdivsqrt_wrb_valid_i, fdivsqrt_wrb_address_i, fdivsqrt_wrb_data_i,
      input  falu1_wrb_ready_o, falu2_wrb_ready_o, lsu_wrb_ready_o, fdivsqrt_wrb_ready_o,
      input  wr_first_valid_o, wr_first_address_o, wr_first_data_o,
      input  wr_second_valid_o, wr_second_address_o, wr_second_data_o,
      input  wrb_done_o
   );

   modport slave (
      input  flush_i,
      input  falu1_wrb_valid_i, falu1_wrb_address_i, falu1_wrb_data_i,
      input  falu2_wrb_valid_i, falu2_wrb_address_i, falu2_wrb_data_i,
      input  lsu_wrb_valid_i, lsu_wrb_address_i, lsu_wrb_data_i,
      input  fdivsqrt_wrb_valid_i, fdivsqrt_wrb_address_i, fdivsqrt_wrb_data_i,
      output falu1_wrb_ready_o, falu2_wrb_ready_o, lsu_wrb_ready_o, fdivsqrt_wrb_ready_o,
      output wr_first_valid_o, wr_first_address_o, wr_first_data_o,
      output wr_second_valid_o, wr_second_address_o, wr_second_data_o,
      output wrb_done_o
   );
endinterface

// File: rtl/fp_wrb_arbiter.sv
// FP write-back arbiter: one small FIFO per producer (falu1, falu2, lsu,
// fdivsqrt = source 0..3), up to two grants per cycle onto the regfile write
// ports under rotating priority. Heads targeting P0 retire without a port.
// Optional feature: define FP_WRB_PERF_EN to add perf_conflict_cnt_o, a
// saturating count of cycles with more than two eligible heads.
module fp_wrb_arbiter #(
   parameter int REG_SIZE_WIDTH = 6,
   parameter int DATA_WIDTH     = 64,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic              clk,
   input  logic              rst,
   fp_wrb_arbiter_if.slave   wrb
`ifdef FP_WRB_PERF_EN
   ,
   output logic [31:0]       perf_conflict_cnt_o
`endif
);

   localparam int NSRC  = 4;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   // Producer side, packed by source index
   logic                                 flush;
   logic [NSRC-1:0]                      in_valid;
   logic [NSRC-1:0][REG_SIZE_WIDTH-1:0]  in_addr;
   logic [NSRC-1:0][DATA_WIDTH-1:0]      in_data;
   logic [NSRC-1:0]                      ready;
   logic [NSRC-1:0]                      push;
   logic [NSRC-1:0]                      pop;

   // FIFO state
   logic [REG_SIZE_WIDTH-1:0]            addr_mem [NSRC][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]                data_mem [NSRC][FIFO_DEPTH];
   logic [NSRC-1:0][PTR_W-1:0]           wr_ptr;
   logic [NSRC-1:0][PTR_W-1:0]           rd_ptr;
   logic [NSRC-1:0][CNT_W-1:0]           count;
   logic [1:0]                           rr_ptr;

   // Head view and arbitration results
   logic [NSRC-1:0][REG_SIZE_WIDTH-1:0]  head_addr;
   logic [NSRC-1:0][DATA_WIDTH-1:0]      head_data;
   logic [NSRC-1:0]                      head_zero;
   logic [NSRC-1:0]                      eligible;
   logic [NSRC-1:0]                      grant;
   logic                                 first_hit;
   logic                                 second_hit;
   logic [1:0]                           first_idx;
   logic [1:0]                           second_idx;
   logic [1:0]                           cand;
   logic [1:0]                           rr_next;

   assign flush    = wrb.flush_i;
   assign in_valid = {wrb.fdivsqrt_wrb_valid_i, wrb.lsu_wrb_valid_i,
                      wrb.falu2_wrb_valid_i, wrb.falu1_wrb_valid_i};
   assign in_addr  = {wrb.fdivsqrt_wrb_address_i, wrb.lsu_wrb_address_i,
                      wrb.falu2_wrb_address_i, wrb.falu1_wrb_address_i};
   assign in_data  = {wrb.fdivsqrt_wrb_data_i, wrb.lsu_wrb_data_i,
                      wrb.falu2_wrb_data_i, wrb.falu1_wrb_data_i};

   // Head decode and acceptance; ready depends only on registered count and flush
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
      head_addr = '0;
      head_data = '0;
      head_zero = '0;
      eligible  = '0;
      ready     = '0;
      push      = '0;
      for (int s = 0; s < NSRC; s++) begin
         head_addr[s] = addr_mem[s][rd_ptr[s]];
         head_data[s] = data_mem[s][rd_ptr[s]];
         head_zero[s] = (count[s] != '0) && (head_addr[s] == '0);
         eligible[s]  = (count[s] != '0) && (head_addr[s] != '0);
         ready[s]     = (count[s] != CNT_W'(FIFO_DEPTH)) && !flush;
         push[s]      = in_valid[s] && ready[s];
      end
   end

   // Rotating-priority scan picking up to two eligible heads starting at rr_ptr
   always_comb begin
      first_hit  = 1'b0;
      second_hit = 1'b0;
      first_idx  = '0;
      second_idx = '0;
      cand       = '0;
      grant      = '0;
      if (!flush) begin
         for (int i = 0; i < NSRC; i++) begin
            cand = rr_ptr + 2'(i);
            if (eligible[cand]) begin
               if (!first_hit) begin
                  first_hit = 1'b1;
                  first_idx = cand;
               end else if (!second_hit) begin
                  second_hit = 1'b1;
                  second_idx = cand;
               end
            end
         end
      end
      if (first_hit)  grant[first_idx]  = 1'b1;
      if (second_hit) grant[second_idx] = 1'b1;
      pop = flush ? '0 : (grant | head_zero);
      if (second_hit)     rr_next = second_idx + 2'd1;
      else if (first_hit) rr_next = first_idx + 2'd1;
      else                rr_next = rr_ptr;
   end

   assign wrb.falu1_wrb_ready_o    = ready[0];
   assign wrb.falu2_wrb_ready_o    = ready[1];
   assign wrb.lsu_wrb_ready_o      = ready[2];
   assign wrb.fdivsqrt_wrb_ready_o = ready[3];

   assign wrb.wr_first_valid_o    = first_hit;
   assign wrb.wr_first_address_o  = first_hit ? head_addr[first_idx] : '0;
   assign wrb.wr_first_data_o     = first_hit ? head_data[first_idx] : '0;
   assign wrb.wr_second_valid_o   = second_hit;
   assign wrb.wr_second_address_o = second_hit ? head_addr[second_idx] : '0;
   assign wrb.wr_second_data_o    = second_hit ? head_data[second_idx] : '0;
   assign wrb.wrb_done_o          = pop;

   // FIFO pointers, counts and round-robin pointer; flush empties everything
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rr_ptr <= '0;
      end else begin
         for (int s = 0; s < NSRC; s++) begin
            if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
            if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
            case ({push[s], pop[s]})
               2'b10:   count[s] <= count[s] + CNT_W'(1);
               2'b01:   count[s] <= count[s] - CNT_W'(1);
               default: count[s] <= count[s];
            endcase
         end
         rr_ptr <= rr_next;
      end
   end

   // FIFO storage writes
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; counts gate every read, so stale entries are never observed.
      for (int s = 0; s < NSRC; s++) begin
         if (push[s]) begin
            addr_mem[s][wr_ptr[s]] <= in_addr[s];
            data_mem[s][wr_ptr[s]] <= in_data[s];
         end
      end
   end

`ifdef FP_WRB_PERF_EN
   // Saturating count of unflushed cycles with more than two eligible heads
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_conflict_cnt_o <= '0;
      end else if (!flush && ($countones(eligible) > 2) && (perf_conflict_cnt_o != '1)) begin
         perf_conflict_cnt_o <= perf_conflict_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fp_wrb_arbiter.sv
// Directed, table-driven bench for fp_wrb_arbiter. Each table row is one
// cycle: inputs driven after the falling edge, outputs compared 1 ns later.
module tb_fp_wrb_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fp_wrb_arbiter_if bus ();

`ifdef FP_WRB_PERF_EN
   logic [31:0] perf_cnt;
`endif

   fp_wrb_arbiter dut (
      .clk (clk),
      .rst (rst),
      .wrb (bus.slave)
`ifdef FP_WRB_PERF_EN
      ,
      .perf_conflict_cnt_o (perf_cnt)
`endif
   );

   typedef struct {
      bit              do_rst;
      bit              flush;
      logic [3:0]      valid;
      logic [3:0][5:0] addr;
      logic [3:0][15:0] data;
      logic [3:0]      exp_ready;
      logic            exp_v1;
      logic [5:0]      exp_a1;
      logic [15:0]     exp_d1;
      logic            exp_v2;
      logic [5:0]      exp_a2;
      logic [15:0]     exp_d2;
      logic [3:0]      exp_done;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic add(input bit r, input bit fl, input logic [3:0] v,
                      input logic [3:0][5:0] a, input logic [3:0][15:0] d,
                      input logic [3:0] rdy,
                      input logic v1, input logic [5:0] a1, input logic [15:0] d1,
                      input logic v2, input logic [5:0] a2, input logic [15:0] d2,
                      input logic [3:0] done);
      vec_t t;
      t.do_rst = r;  t.flush = fl; t.valid = v; t.addr = a; t.data = d;
      t.exp_ready = rdy;
      t.exp_v1 = v1; t.exp_a1 = a1; t.exp_d1 = d1;
      t.exp_v2 = v2; t.exp_a2 = a2; t.exp_d2 = d2;
      t.exp_done = done;
      vecs.push_back(t);
   endtask

   task automatic add_rst();
      add(1, 0, 4'b0, '0, '0, 4'b0, 0, 0, 0, 0, 0, 0, 4'b0);
   endtask

   task automatic add_idle(input logic [3:0] v, input logic [3:0][5:0] a, input logic [3:0][15:0] d);
      add(0, 0, v, a, d, 4'b1111, 0, 0, 0, 0, 0, 0, 4'b0);
   endtask

   task automatic drive(input bit fl, input logic [3:0] v, input logic [3:0][5:0] a, input logic [3:0][15:0] d);
      bus.flush_i                = fl;
      bus.falu1_wrb_valid_i      = v[0];
      bus.falu1_wrb_address_i    = a[0];
      bus.falu1_wrb_data_i       = {4{d[0]}};
      bus.falu2_wrb_valid_i      = v[1];
      bus.falu2_wrb_address_i    = a[1];
      bus.falu2_wrb_data_i       = {4{d[1]}};
      bus.lsu_wrb_valid_i        = v[2];
      bus.lsu_wrb_address_i      = a[2];
      bus.lsu_wrb_data_i         = {4{d[2]}};
      bus.fdivsqrt_wrb_valid_i   = v[3];
      bus.fdivsqrt_wrb_address_i = a[3];
      bus.fdivsqrt_wrb_data_i    = {4{d[3]}};
   endtask

   function automatic logic [3:0] ready_vec();
      return {bus.fdivsqrt_wrb_ready_o, bus.lsu_wrb_ready_o,
              bus.falu2_wrb_ready_o, bus.falu1_wrb_ready_o};
   endfunction

   task automatic reset_cycle();
      @(negedge clk);
      rst = 1'b1;
      drive(0, 4'b0, '0, '0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      drive(0, 4'b0, '0, '0);
      repeat (2) @(posedge clk);

      // Single transfer from falu1
      add_rst();
      add_idle(4'b0001, {6'd0, 6'd0, 6'd0, 6'd5}, {16'h0, 16'h0, 16'h0, 16'h00A5});
      add(0, 0, 4'b0, '0, '0, 4'b1111, 1, 6'd5, 16'h00A5, 0, 0, 0, 4'b0001);
      add_idle(4'b0, '0, '0);
      // Four-way conflict, then rr_ptr check and wrap-around
      add_rst();
      add_idle(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, {16'h0044, 16'h0033, 16'h0022, 16'h0011});
      add(0, 0, 4'b0, '0, '0, 4'b1111, 1, 6'd1, 16'h0011, 1, 6'd2, 16'h0022, 4'b0011);
      add(0, 0, 4'b0, '0, '0, 4'b1111, 1, 6'd3, 16'h0033, 1, 6'd4, 16'h0044, 4'b1100);
      add_idle(4'b0110, {6'd0, 6'd10, 6'd9, 6'd0}, {16'h0, 16'h00A0, 16'h0090, 16'h0});
      add(0, 0, 4'b0, '0, '0, 4'b1111, 1, 6'd9, 16'h0090, 1, 6'd10, 16'h00A0, 4'b0110);
      add_idle(4'b1001, {6'd12, 6'd0, 6'd0, 6'd13}, {16'h00C0, 16'h0, 16'h0, 16'h00D0});
      add(0, 0, 4'b0, '0, '0, 4'b1111, 1, 6'd12, 16'h00C0, 1, 6'd13, 16'h00D0, 4'b1001);
      // Backpressure on lsu, order preserved
      add_rst();
      add_idle(4'b0111, {6'd0, 6'd30, 6'd22, 6'd20}, {16'h0, 16'h00C0, 16'h00B0, 16'h00A0});
      add(0, 0, 4'b0111, {6'd0, 6'd31, 6'd23, 6'd21}, {16'h0, 16'h00C1, 16'h00B1, 16'h00A1},
          4'b1111, 1, 6'd20, 16'h00A0, 1, 6'd22, 16'h00B0, 4'b0011);
      add(0, 0, 4'b0100, {6'd0, 6'd32, 6'd0, 6'd0}, {16'h0, 16'h00C2, 16'h0, 16'h0},
          4'b1011, 1, 6'd30, 16'h00C0, 1, 6'd21, 16'h00A1, 4'b0101);
      add(0, 0, 4'b0100, {6'd0, 6'd32, 6'd0, 6'd0}, {16'h0, 16'h00C2, 16'h0, 16'h0},
          4'b1111, 1, 6'd23, 16'h00B1, 1, 6'd31, 16'h00C1, 4'b0110);
      add(0, 0, 4'b0, '0, '0, 4'b1111, 1, 6'd32, 16'h00C2, 0, 0, 0, 4'b0100);
      add_idle(4'b0, '0, '0);
      // P0 drop alongside a real write
      add_rst();
      add_idle(4'b1010, {6'd0, 6'd0, 6'd7, 6'd0}, {16'h00FF, 16'h0, 16'h0077, 16'h0});
      add(0, 0, 4'b0, '0, '0, 4'b1111, 1, 6'd7, 16'h0077, 0, 0, 0, 4'b1010);
      add_idle(4'b0, '0, '0);
      // Flush mid-operation
      add_rst();
      add_idle(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, {16'h4, 16'h3, 16'h2, 16'h1});
      add(0, 0, 4'b1111, {6'd8, 6'd7, 6'd6, 6'd5}, {16'h8, 16'h7, 16'h6, 16'h5},
          4'b1111, 1, 6'd1, 16'h1, 1, 6'd2, 16'h2, 4'b0011);
      add(0, 1, 4'b1111, {6'd12, 6'd11, 6'd10, 6'd9}, {16'hC, 16'hB, 16'hA, 16'h9},
          4'b0000, 0, 0, 0, 0, 0, 0, 4'b0);
      add_idle(4'b0110, {6'd0, 6'd14, 6'd13, 6'd0}, {16'h0, 16'hE, 16'hD, 16'h0});
      add(0, 0, 4'b0, '0, '0, 4'b1111, 1, 6'd13, 16'hD, 1, 6'd14, 16'hE, 4'b0110);
      add_idle(4'b0, '0, '0);

      foreach (vecs[k]) begin
         @(negedge clk);
         rst = vecs[k].do_rst;
         drive(vecs[k].flush, vecs[k].valid, vecs[k].addr, vecs[k].data);
         #1;
         if (!vecs[k].do_rst) begin
            check($sformatf("row%0d ready", k), 64'(ready_vec()), 64'(vecs[k].exp_ready));
            check($sformatf("row%0d first", k), 64'({bus.wr_first_valid_o, bus.wr_first_address_o}),
                  64'({vecs[k].exp_v1, vecs[k].exp_a1}));
            check($sformatf("row%0d first_data", k), bus.wr_first_data_o, {4{vecs[k].exp_d1}});
            check($sformatf("row%0d second", k), 64'({bus.wr_second_valid_o, bus.wr_second_address_o}),
                  64'({vecs[k].exp_v2, vecs[k].exp_a2}));
            check($sformatf("row%0d second_data", k), bus.wr_second_data_o, {4{vecs[k].exp_d2}});
            check($sformatf("row%0d done", k), 64'(bus.wrb_done_o), 64'(vecs[k].exp_done));
         end
      end

      // All four stream continuously: grants alternate between the two pairs
      reset_cycle();
      for (int k = 0; k < 7; k++) begin
         drive(0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, {16'h44, 16'h33, 16'h22, 16'h11});
         #1;
         check($sformatf("stream%0d done", k), 64'(bus.wrb_done_o),
               64'((k == 0) ? 4'b0000 : ((k % 2 == 1) ? 4'b0011 : 4'b1100)));
         check($sformatf("stream%0d first_addr", k), 64'(bus.wr_first_address_o),
               64'((k == 0) ? 6'd0 : ((k % 2 == 1) ? 6'd1 : 6'd3)));
         @(negedge clk);
      end
      drive(0, 4'b0, '0, '0);

`ifdef FP_WRB_PERF_EN
      // Three sources kept non-empty for four cycles
      reset_cycle();
      #1;
      check("perf after reset", 64'(perf_cnt), 64'd0);
      for (int k = 0; k < 5; k++) begin
         drive(0, 4'b0111, {6'd0, 6'd3, 6'd2, 6'd1}, {16'h0, 16'h3, 16'h2, 16'h1});
         @(negedge clk);
      end
      drive(0, 4'b0, '0, '0);
      #1;
      check("perf conflict count", 64'(perf_cnt), 64'd4);
      reset_cycle();
      #1;
      check("perf cleared by rst", 64'(perf_cnt), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
